// File: rtl/sync_event_count_pkg.sv
// ---------------------------------------------------------------------------
// sync_event_count_pkg
//   Shared types for the sync_event_count slice.
//   srcState_t : source-side handshake state (ready to launch / waiting ack).
// ---------------------------------------------------------------------------
package sync_event_count_pkg;

    typedef enum logic {
        SRC_READY = 1'b0,
        SRC_BUSY  = 1'b1
    } srcState_t;

endpackage

// File: rtl/sync_toggle_ack.sv
// ---------------------------------------------------------------------------
// sync_toggle_ack
//   Toggle request / toggle acknowledge crossing between sCLK and dCLK.
//   Ports:
//     sCLK, sRST_N : source clock, async active-low reset (resets both sides)
//     dCLK         : destination clock
//     sLaunch  in  : start a transfer (honoured only while sRdy)
//     sRdy     out : no transfer in flight
//     dEdge    out : one-dCLK pulse when a new request has arrived
// ---------------------------------------------------------------------------
module sync_toggle_ack
    import sync_event_count_pkg::*;
(
    input  logic sCLK,
    input  logic sRST_N,
    input  logic dCLK,
    input  logic sLaunch,
    output logic sRdy,
    output logic dEdge
);

    srcState_t state;
    srcState_t stateNext;

    logic sTog;
    logic sSync1;
    logic sSync2;
    logic sLast;
    logic sAckEdge;

    logic dSync1;
    logic dSync2;
    logic dLast;
    logic dAck;

    // Source handshake state register
    always_ff @(posedge sCLK or negedge sRST_N) begin
        if (!sRST_N) begin
            state <= SRC_READY;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            SRC_READY: if (sLaunch)  stateNext = SRC_BUSY;
            SRC_BUSY:  if (sAckEdge) stateNext = SRC_READY;
            default:                 stateNext = SRC_READY;
        endcase
    end

    // Output logic
    always_comb begin
        sRdy = (state == SRC_READY);
    end

    // Request toggle plus ack synchronizer; sLast holds the previous sample so
    // the ack edge is seen exactly once.
    always_ff @(posedge sCLK or negedge sRST_N) begin
        if (!sRST_N) begin
            sTog   <= 1'b0;
            sSync1 <= 1'b0;
            sSync2 <= 1'b0;
            sLast  <= 1'b0;
        end else begin
            if (sLaunch && sRdy) begin
                sTog <= ~sTog;
            end
            sSync1 <= dAck;
            sSync2 <= sSync1;
            sLast  <= sSync2;
        end
    end

    assign sAckEdge = sSync2 ^ sLast;

    // Request synchronizer and ack toggle on the destination side
    always_ff @(posedge dCLK or negedge sRST_N) begin
        if (!sRST_N) begin
            dSync1 <= 1'b0;
            dSync2 <= 1'b0;
            dLast  <= 1'b0;
            dAck   <= 1'b0;
        end else begin
            dSync1 <= sTog;
            dSync2 <= dSync1;
            dLast  <= dSync2;
            if (dEdge) begin
                dAck <= ~dAck;
            end
        end
    end

    assign dEdge = dSync2 ^ dLast;

endmodule

// File: rtl/sync_event_count.sv
// ---------------------------------------------------------------------------
// sync_event_count
//   Counts 1-bit events on sCLK and delivers batched counts to dCLK through
//   a toggle handshake. Events keep accruing while a batch is in flight.
//   Ports:
//     sCLK, sRST_N : source clock, async active-low reset (both domains)
//     sEVT     in  : one event per sCLK cycle while high
//     sBUSY    out : batch in flight
//     sSAT     out : sticky, an event was dropped at accumulator saturation
//     sSAT_CLR in  : clears sSAT (wins over a simultaneous set)
//     dCLK     in  : destination clock
//     dVALID   out : one-dCLK strobe, dCOUNT just updated
//     dCOUNT   out : last delivered batch count
//   hold -> dCOUNT is a quasi-static multi-cycle path (false path).
// ---------------------------------------------------------------------------
module sync_event_count
    import sync_event_count_pkg::*;
#(
    parameter int unsigned width = 8
) (
    input  logic             sCLK,
    input  logic             sRST_N,
    input  logic             sEVT,
    output logic             sBUSY,
    output logic             sSAT,
    input  logic             sSAT_CLR,
    input  logic             dCLK,
    output logic             dVALID,
    output logic [width-1:0] dCOUNT
);

    localparam logic [width-1:0] MAXCNT = '1;

    logic [width-1:0] acc;
    logic [width-1:0] hold;
    logic [width-1:0] sum;
    logic             drop;
    logic             sLaunch;
    logic             sRdy;
    logic             dEdge;

    // Saturating accumulate; the current event is part of sum so a launch in
    // this cycle carries it in hold and acc restarts from zero.
    always_comb begin
        drop    = (acc == MAXCNT) && sEVT;
        sum     = drop ? acc : acc + {{(width-1){1'b0}}, sEVT};
        sLaunch = sRdy && (sum != '0);
    end

    always_ff @(posedge sCLK or negedge sRST_N) begin
        if (!sRST_N) begin
            acc  <= '0;
            hold <= '0;
            sSAT <= 1'b0;
        end else begin
            acc <= sLaunch ? '0 : sum;
            if (sLaunch) begin
                hold <= sum;
            end
            if (sSAT_CLR) begin
                sSAT <= 1'b0;
            end else if (drop) begin
                sSAT <= 1'b1;
            end
        end
    end

    sync_toggle_ack uSync (
        .sCLK    (sCLK),
        .sRST_N  (sRST_N),
        .dCLK    (dCLK),
        .sLaunch (sLaunch),
        .sRdy    (sRdy),
        .dEdge   (dEdge)
    );

    assign sBUSY = ~sRdy;

    // hold is stable from launch until ack returns, so sampling it on dEdge
    // is safe without a data synchronizer.
    always_ff @(posedge dCLK or negedge sRST_N) begin
        if (!sRST_N) begin
            dVALID <= 1'b0;
            dCOUNT <= '0;
        end else begin
            dVALID <= dEdge;
            if (dEdge) begin
                dCOUNT <= hold;
            end
        end
    end

endmodule

// File: tb/tb_sync_event_count.sv
// ---------------------------------------------------------------------------
// tb_sync_event_count
//   Directed and random stimulus for sync_event_count at two clock ratios
//   (dCLK 17ns and 4ns against sCLK 10ns). Expected totals come from counting
//   injected events; delivered strobes are gathered by a dCLK-side monitor.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sync_event_count;

    localparam int unsigned W    = 8;
    localparam int          MAXV = (1 << W) - 1;

    logic         sCLK = 1'b0;
    logic         dCLK = 1'b0;
    logic         sRST_N = 1'b0;
    logic         sEVT = 1'b0;
    logic         sSAT_CLR = 1'b0;
    logic         sBUSY;
    logic         sSAT;
    logic         dVALID;
    logic [W-1:0] dCOUNT;

    real dHalf = 8.5;
    bit  dRun  = 1'b1;

    int passed   = 0;
    int total    = 0;
    int injected = 0;

    // monitor accumulators (written only by the monitor)
    int deliveredSum = 0;
    int strobes      = 0;
    int zeroStrobes  = 0;
    int wideStrobes  = 0;
    int lastCount    = 0;
    bit prevValid    = 1'b0;

    sync_event_count #(.width(W)) dut (
        .sCLK     (sCLK),
        .sRST_N   (sRST_N),
        .sEVT     (sEVT),
        .sBUSY    (sBUSY),
        .sSAT     (sSAT),
        .sSAT_CLR (sSAT_CLR),
        .dCLK     (dCLK),
        .dVALID   (dVALID),
        .dCOUNT   (dCOUNT)
    );

    always #5 sCLK = ~sCLK;

    always begin
        #(dHalf);
        if (dRun) dCLK = ~dCLK;
    end

    always @(negedge dCLK) begin
        if (dVALID) begin
            strobes      <= strobes + 1;
            deliveredSum <= deliveredSum + int'(dCOUNT);
            lastCount    <= int'(dCOUNT);
            if (dCOUNT == '0) zeroStrobes <= zeroStrobes + 1;
            if (prevValid)    wideStrobes <= wideStrobes + 1;
        end
        prevValid <= dVALID;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick(input logic e);
        @(negedge sCLK);
        sEVT = e;
        injected += int'(e);
    endtask

    // Wait for the source side to stay idle long enough that no launch is pending.
    task automatic waitIdle(input string tag);
        int quiet = 0;
        int n = 0;
        tick(1'b0);
        while (quiet < 4 && n < 3000) begin
            @(negedge sCLK);
            n++;
            if (!sBUSY) quiet++;
            else        quiet = 0;
        end
        repeat (4) @(negedge dCLK);
        check({tag, " idle"}, 32'(quiet >= 4), 32'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, " sBUSY"},  32'(sBUSY),  32'd0);
        check({tag, " sSAT"},   32'(sSAT),   32'd0);
        check({tag, " dVALID"}, 32'(dVALID), 32'd0);
        check({tag, " dCOUNT"}, 32'(dCOUNT), 32'd0);
    endtask

    initial begin
        int injBase;
        int sumBase;
        int strBase;
        bit hit;

        for (int r = 0; r < 2; r++) begin
            dHalf = (r == 0) ? 8.5 : 2.0;
            dRun  = 1'b1;

            // ---- reset ----
            sEVT = 1'b0;
            #3 sRST_N = 1'b0;
            #4;
            checkResetOutputs("reset");
            repeat (3) @(negedge sCLK);
            sRST_N = 1'b1;
            repeat (4) @(negedge sCLK);

            // ---- 1) single event ----
            strBase = strobes;
            tick(1'b1);
            tick(1'b0);
            check("single busy", 32'(sBUSY), 32'd1);
            waitIdle("single");
            check("single strobes", 32'(strobes - strBase), 32'd1);
            check("single count",   32'(lastCount),         32'd1);
            check("single busy low", 32'(sBUSY),            32'd0);

            // ---- 2) 100 back-to-back events ----
            injBase = injected; sumBase = deliveredSum; strBase = zeroStrobes;
            repeat (100) tick(1'b1);
            waitIdle("burst");
            check("burst sum",   32'(deliveredSum - sumBase), 32'(injected - injBase));
            check("burst zero",  32'(zeroStrobes - strBase),  32'd0);

            // ---- 3) saturation with dCLK stopped ----
            strBase = strobes; sumBase = deliveredSum;
            dRun = 1'b0;
            repeat (MAXV + 20) tick(1'b1);
            tick(1'b0);
            check("sat busy", 32'(sBUSY), 32'd1);
            check("sat flag", 32'(sSAT),  32'd1);
            dRun = 1'b1;
            waitIdle("sat");
            check("sat strobes", 32'(strobes - strBase),      32'd2);
            check("sat sum",     32'(deliveredSum - sumBase), 32'(MAXV + 1));
            check("sat last",    32'(lastCount),              32'(MAXV));
            check("sat sticky",  32'(sSAT),                   32'd1);
            @(negedge sCLK) sSAT_CLR = 1'b1;
            @(negedge sCLK) sSAT_CLR = 1'b0;
            check("sat clear",   32'(sSAT),                   32'd0);

            // ---- 4) events around launch and ready rise ----
            injBase = injected; sumBase = deliveredSum;
            tick(1'b1);
            hit = 1'b0;
            for (int i = 0; i < 300 && !hit; i++) begin
                @(negedge sCLK);
                if (!sBUSY) begin
                    sEVT = 1'b1;
                    injected++;
                    hit = 1'b1;
                end else begin
                    sEVT = i[0];
                    injected += i[0];
                end
            end
            check("edge ready seen", 32'(hit), 32'd1);
            waitIdle("edge");
            check("edge sum", 32'(deliveredSum - sumBase), 32'(injected - injBase));

            // ---- 5) reset mid-transfer ----
            tick(1'b1);
            tick(1'b0);
            #2 sRST_N = 1'b0;
            #1;
            checkResetOutputs("midreset");
            repeat (3) @(negedge sCLK);
            sRST_N = 1'b1;
            strBase = strobes; sumBase = deliveredSum; injBase = injected;
            repeat (20) tick(1'b0);
            check("aborted no strobe", 32'(strobes - strBase), 32'd0);
            repeat (3) tick(1'b1);
            waitIdle("post reset");
            check("post reset sum", 32'(deliveredSum - sumBase), 32'd3);

            // ---- 6) random events ----
            injBase = injected; sumBase = deliveredSum;
            strBase = zeroStrobes;
            begin
                int wideBase = wideStrobes;
                for (int i = 0; i < 10000; i++) tick(1'(($urandom % 10) < 3));
                waitIdle("random");
                check("random sum",  32'(deliveredSum - sumBase), 32'(injected - injBase));
                check("random zero", 32'(zeroStrobes - strBase),  32'd0);
                check("random wide", 32'(wideStrobes - wideBase), 32'd0);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
